// File: rtl/ifetch_queue_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifetch_queue_param
// Description : Instruction-fetch front end. Requests aligned blocks from the
//               I-cache, buffers them in a circular block queue and presents
//               one instruction per cycle with its PC to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue_param #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int IFQ_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  Read_enable,
  input  logic                                  jump_branch_valid,
  input  logic [ADDRESS_WIDTH-1:0]              jump_branch_address,
  output logic                                  icache_req,
  output logic [ADDRESS_WIDTH-1:0]              icache_addr,
  input  logic                                  icache_rdata_valid,
  input  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] icache_rdata,
  output logic [DATA_WIDTH-1:0]                 instruction,
  output logic [ADDRESS_WIDTH-1:0]              PC_out,
  output logic                                  instr_valid,
  output logic                                  empty,
  output logic                                  full
);

  localparam int                       c_OFFW     = $clog2(WORDS_PER_BLOCK);
  localparam int                       c_PW       = $clog2(IFQ_DEPTH);
  localparam logic [c_PW:0]            c_DEPTH    = (c_PW+1)'(IFQ_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_OFF_MASK = ADDRESS_WIDTH'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_BLK_INC  = ADDRESS_WIDTH'(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDRESS_WIDTH-1:0]   r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0]   r_pc;
  logic [c_PW:0]              r_wp;
  logic [c_PW:0]              r_rp;
  logic [c_PW:0]              r_count;
  logic [c_OFFW-1:0]          r_offset;
  logic [DATA_WIDTH-1:0]      r_mem [IFQ_DEPTH][WORDS_PER_BLOCK];

  logic                       w_req;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_blk_pop;
  logic                       w_empty;
  logic [DATA_WIDTH-1:0]      w_head;

  always_comb begin
    w_empty     = (r_count == '0);
    w_req       = (r_state == S_IDLE) && (r_count != c_DEPTH) && !jump_branch_valid;
    w_push      = (r_state == S_WAIT) && icache_rdata_valid && !jump_branch_valid;
    w_pop       = Read_enable && !w_empty && !jump_branch_valid;
    w_blk_pop   = w_pop && (r_offset == '1);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_state_nxt = S_WAIT;
      // A response arriving together with a flush completes the request,
      // so only a still-pending request needs to be drained in DROP.
      S_WAIT: begin
        if (icache_rdata_valid)     w_state_nxt = S_IDLE;
        else if (jump_branch_valid) w_state_nxt = S_DROP;
      end
      S_DROP: if (icache_rdata_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_pc       <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_offset   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (jump_branch_valid) begin
        r_wp       <= '0;
        r_rp       <= '0;
        r_count    <= '0;
        r_offset   <= jump_branch_address[c_OFFW-1:0];
        r_fetch_pc <= jump_branch_address & ~c_OFF_MASK;
        r_pc       <= jump_branch_address;
      end else begin
        if (w_push) begin
          r_wp       <= r_wp + 1'b1;
          r_fetch_pc <= r_fetch_pc + c_BLK_INC;
        end
        if (w_pop) begin
          r_offset <= r_offset + 1'b1;
          r_pc     <= r_pc + 1'b1;
        end
        if (w_blk_pop) r_rp <= r_rp + 1'b1;
        if (w_push && !w_blk_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_blk_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        r_mem[r_wp[c_PW-1:0]][i] <= icache_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_head      = r_mem[r_rp[c_PW-1:0]][r_offset];
  // The request strobe is forced low while reset is held.
  assign icache_req  = w_req && reset;
  assign icache_addr = r_fetch_pc;
  assign PC_out      = r_pc;
  assign instruction = w_empty ? '0 : w_head;
  assign instr_valid = !w_empty;
  assign empty       = w_empty;
  assign full        = (r_count == c_DEPTH);

endmodule
`default_nettype wire
